// File: rtl/data_ram_responder_pkg.sv
// Shared types and default widths for the data RAM responder and the processor top.
package data_ram_responder_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam int unsigned DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } resp_state_t;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_ram_responder_ram_sp_sync.sv
// Single-port synchronous RAM: registered read, write-enable, no output reset.
module ram_sp_sync #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned IDX_W  = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on reads, so consumers may treat it as held data
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Image RAM responder: host load, processor access, result dump.
// Optional access counters enabled with `define RAM_ACCESS_STATS_EN.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W    = DATA_W_DEFAULT,
    parameter int unsigned MEM_DEPTH = 65536,
    parameter int unsigned LOAD_LEN  = 16384,
    parameter int unsigned DUMP_BASE = 16384,
    parameter int unsigned DUMP_LEN  = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RAM_ADDRESS,
    input  logic [DATA_W-1:0] DATA_BUS_out,
    output logic [DATA_W-1:0] DATA_BUS_in,
    input  logic              M_Write,
    input  logic              RAM_en,
    input  logic              End_of_process,
    output logic              proc_run,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic              err_oob,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int unsigned IDX_W = idx_width(MEM_DEPTH);
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] LOAD_LAST  = PTR_W'(LOAD_LEN - 1);
    localparam logic [PTR_W-1:0] DUMP_LAST  = PTR_W'(DUMP_LEN - 1);
    localparam logic [PTR_W-1:0] DEPTH_P    = PTR_W'(MEM_DEPTH);
    localparam logic [IDX_W-1:0] DUMP_START = IDX_W'(DUMP_BASE % MEM_DEPTH);
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(MEM_DEPTH - 1);

    resp_state_t       state, state_nxt;
    logic [PTR_W-1:0]  load_ptr, dump_ptr;
    logic [IDX_W-1:0]  dump_addr;
    logic              ram_en, ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic              proc_oob, proc_rd, load_hs, dump_hs;
    logic              pend_rd, pend_oob;
    logic [DATA_W-1:0] dbus_hold;

    assign proc_oob = {1'b0, RAM_ADDRESS} >= DEPTH_P;
    assign proc_rd  = (state == ST_RUN) && RAM_en && !M_Write;
    assign load_hs  = in_valid && in_ready;
    assign dump_hs  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (LOAD_LEN == 0 || (load_hs && load_ptr == LOAD_LAST)) state_nxt = ST_RUN;
            ST_RUN:  if (End_of_process) state_nxt = (DUMP_LEN == 0) ? ST_DONE : ST_DUMP;
            ST_DUMP: if (dump_hs && dump_ptr == DUMP_LAST) state_nxt = ST_DONE;
            default: ;
        endcase
    end

    always_comb begin
        proc_run  = (state == ST_RUN);
        in_ready  = (state == ST_LOAD) && (LOAD_LEN != 0) && !rst;
        done      = (state == ST_DONE);
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ST_LOAD: begin
                ram_en    = load_hs;
                ram_we    = load_hs;
                ram_addr  = IDX_W'(load_ptr);
                ram_wdata = in_data;
            end
            ST_RUN: begin
                ram_en    = RAM_en && !proc_oob;
                ram_we    = M_Write;
                ram_addr  = IDX_W'(RAM_ADDRESS);
                ram_wdata = DATA_BUS_out;
            end
            ST_DUMP: begin
                ram_en   = !out_valid;
                ram_addr = dump_addr;
            end
            default: ;
        endcase
    end

    ram_sp_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            load_ptr  <= '0;
            dump_ptr  <= '0;
            dump_addr <= DUMP_START;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pend_rd   <= 1'b0;
            pend_oob  <= 1'b0;
            dbus_hold <= '0;
            err_oob   <= 1'b0;
        end else begin
            if (load_hs) load_ptr <= load_ptr + PTR_W'(1);
            pend_rd  <= proc_rd;
            pend_oob <= proc_oob;
            if (pend_rd) dbus_hold <= DATA_BUS_in;
            if (state == ST_RUN && RAM_en && proc_oob) err_oob <= 1'b1;
            // Read is issued whenever the dump slot is empty; data shows one cycle later
            if (state == ST_DUMP) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_last  <= (dump_ptr == DUMP_LAST);
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    dump_ptr  <= dump_ptr + PTR_W'(1);
                    dump_addr <= (dump_addr == IDX_MAX) ? '0 : dump_addr + IDX_W'(1);
                end
            end
        end
    end

    assign DATA_BUS_in = pend_rd ? (pend_oob ? '0 : ram_rdata) : dbus_hold;
    assign out_data    = out_valid ? ram_rdata : '0;

`ifdef RAM_ACCESS_STATS_EN
    logic proc_wr;
    assign proc_wr = (state == ST_RUN) && RAM_en && M_Write;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (proc_rd && rd_count != '1) rd_count <= rd_count + 32'd1;
            if (proc_wr && wr_count != '1) wr_count <= wr_count + 32'd1;
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized bench for data_ram_responder against a transaction-level memory model.
module tb_data_ram_responder;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned LLEN   = 4;
    localparam int unsigned BASE   = 2;
    localparam int unsigned BASE_W = 4095;
    localparam int unsigned DLEN   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] RAM_ADDRESS = '0, DATA_BUS_out = '0, in_data = '0;
    logic        M_Write = 1'b0, RAM_en = 1'b0, End_of_process = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;

    logic [15:0] dbus, out_data, dbus_w, out_data_w;
    logic        proc_run, in_ready, out_valid, out_last, done, err_oob;
    logic        proc_run_w, in_ready_w, out_valid_w, out_last_w, done_w, err_oob_w;
    logic [31:0] rd_count, wr_count, rd_count_w, wr_count_w;

    always #5 clk = ~clk;

    data_ram_responder #(
        .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH),
        .LOAD_LEN(LLEN), .DUMP_BASE(BASE), .DUMP_LEN(DLEN)
    ) u_dut (
        .clk(clk), .rst(rst), .RAM_ADDRESS(RAM_ADDRESS), .DATA_BUS_out(DATA_BUS_out),
        .DATA_BUS_in(dbus), .M_Write(M_Write), .RAM_en(RAM_en),
        .End_of_process(End_of_process), .proc_run(proc_run), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .done(done), .err_oob(err_oob), .rd_count(rd_count), .wr_count(wr_count)
    );

    // Same stimulus, dump region straddling the top of memory
    data_ram_responder #(
        .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH),
        .LOAD_LEN(LLEN), .DUMP_BASE(BASE_W), .DUMP_LEN(DLEN)
    ) u_dut_wrap (
        .clk(clk), .rst(rst), .RAM_ADDRESS(RAM_ADDRESS), .DATA_BUS_out(DATA_BUS_out),
        .DATA_BUS_in(dbus_w), .M_Write(M_Write), .RAM_en(RAM_en),
        .End_of_process(End_of_process), .proc_run(proc_run_w), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_w), .out_data(out_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_last(out_last_w),
        .done(done_w), .err_oob(err_oob_w), .rd_count(rd_count_w), .wr_count(wr_count_w)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] mdl_mem [DEPTH];
    bit          written [DEPTH];
    int          phase;
    int          nload, ndump;
    bit          ov, exp_oob, chk_en = 1'b0;
    logic [15:0] exp_dbus;
    int          exp_rd, exp_wr;
    logic [15:0] got [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model over the edge just taken, using the inputs held across it
    task automatic model_edge();
        if (rst) begin
            phase = 0; nload = 0; ndump = 0; ov = 0;
            exp_dbus = '0; exp_oob = 0; exp_rd = 0; exp_wr = 0;
            return;
        end
        case (phase)
            0: begin
                if (LLEN == 0) phase = 1;
                else if (in_valid) begin
                    mdl_mem[nload] = in_data;
                    written[nload] = 1'b1;
                    nload++;
                    if (nload == LLEN) phase = 1;
                end
            end
            1: begin
                if (RAM_en) begin
                    if (M_Write) begin
                        exp_wr++;
                        if (RAM_ADDRESS < DEPTH) begin
                            mdl_mem[RAM_ADDRESS] = DATA_BUS_out;
                            written[RAM_ADDRESS] = 1'b1;
                        end else exp_oob = 1;
                    end else begin
                        exp_rd++;
                        if (RAM_ADDRESS < DEPTH) exp_dbus = mdl_mem[RAM_ADDRESS];
                        else begin
                            exp_dbus = '0;
                            exp_oob = 1;
                        end
                    end
                end
                if (End_of_process) phase = (DLEN == 0) ? 3 : 2;
            end
            2: begin
                if (ov && out_ready) begin
                    ov = 0;
                    ndump++;
                    if (ndump == DLEN) phase = 3;
                end else if (!ov) ov = 1;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic acc(input bit w, input logic [15:0] a, input logic [15:0] d);
        RAM_en = 1'b1; M_Write = w; RAM_ADDRESS = a; DATA_BUS_out = d;
        step();
        RAM_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("proc_run", proc_run, phase == 1);
            check("in_ready", in_ready, phase == 0 && !rst);
            check("done", done, phase == 3);
            check("err_oob", err_oob, exp_oob);
            check("DATA_BUS_in", dbus, exp_dbus);
            check("out_valid", out_valid, ov);
            check("out_valid_wrap", out_valid_w, ov);
            check("done_wrap", done_w, phase == 3);
            if (ov) begin
                check("out_data", out_data, mdl_mem[(BASE + ndump) % DEPTH]);
                check("out_last", out_last, ndump == DLEN - 1);
                check("out_data_wrap", out_data_w, mdl_mem[(BASE_W + ndump) % DEPTH]);
                check("out_last_wrap", out_last_w, ndump == DLEN - 1);
            end
`ifdef RAM_ACCESS_STATS_EN
            check("rd_count", rd_count, exp_rd);
            check("wr_count", wr_count, exp_wr);
`else
            check("rd_count", rd_count, 0);
            check("wr_count", wr_count, 0);
`endif
        end
    end

    initial begin
        logic [15:0] words [4];
        int r;
        logic [15:0] a;
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;

        repeat (3) step();
        chk_en = 1'b1;
        check("rst_dbus", dbus, 16'h0000);
        check("rst_proc_run", proc_run, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err_oob", err_oob, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready_first", in_ready, 1'b1);

        // Load with gaps; strobes during load must be ignored
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0; in_data = 16'hDEAD;
            RAM_en = 1'b1; M_Write = i[0]; RAM_ADDRESS = 16'd2; DATA_BUS_out = 16'hBAD0;
            step();
            RAM_en = 1'b0;
            in_valid = 1'b1; in_data = words[i];
            step();
        end
        in_valid = 1'b0;
        check("proc_run_after_load", proc_run, 1'b1);

        acc(1'b0, 16'd2, 16'h0);
        check("read_addr2", dbus, 16'h0033);
        acc(1'b1, 16'd5, 16'hBEEF);
        acc(1'b0, 16'd5, 16'h0);
        check("raw_addr5", dbus, 16'hBEEF);
        acc(1'b1, 16'd4, 16'h4444);
        acc(1'b1, 16'd4095, 16'h5555);
        acc(1'b1, 16'hFFFF, 16'h1234);
        check("oob_flag", err_oob, 1'b1);
        acc(1'b0, 16'hFFFF, 16'h0);
        check("oob_read_zero", dbus, 16'h0000);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            RAM_ADDRESS = 16'($urandom); DATA_BUS_out = 16'($urandom);
            if (r < 3) begin
                RAM_en = 1'b0; M_Write = r[0];
            end else if (r < 6) begin
                a = (r == 5) ? 16'(16'h1000 + $urandom_range(0, 16'hEFFF)) : 16'($urandom_range(0, 7));
                if (a < DEPTH && !written[a]) a = 16'd2;
                RAM_en = 1'b1; M_Write = 1'b0; RAM_ADDRESS = a;
            end else begin
                a = (r == 9) ? 16'(16'h1000 + $urandom_range(0, 16'hEFFF)) : 16'($urandom_range(6, 7));
                RAM_en = 1'b1; M_Write = 1'b1; RAM_ADDRESS = a;
            end
            step();
        end
        RAM_en = 1'b0;

        // Access in the same cycle as End_of_process still lands
        RAM_en = 1'b1; M_Write = 1'b1; RAM_ADDRESS = 16'd3; DATA_BUS_out = 16'h7777;
        End_of_process = 1'b1;
        step();
        RAM_en = 1'b0; End_of_process = 1'b0;
        check("proc_run_after_eop", proc_run, 1'b0);

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            RAM_en = 1'b1; M_Write = 1'b1; RAM_ADDRESS = 16'd2; DATA_BUS_out = 16'hCAFE;
            step();
        end
        RAM_en = 1'b0;
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, 16'h0033);
        check("stall_data_wrap", out_data_w, 16'h5555);

        for (int i = 0; i < 200 && phase != 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) got.push_back(out_data);
            step();
        end
        check("dump_done", done, 1'b1);
        check("dump_count", got.size(), 3);
        if (got.size() == 3) begin
            check("dump_w0", got[0], 16'h0033);
            check("dump_w1", got[1], 16'h7777);
            check("dump_w2", got[2], 16'h4444);
        end

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'h9999;
            RAM_en = 1'b1; M_Write = 1'b0; RAM_ADDRESS = 16'd4;
            step();
        end
        in_valid = 1'b0; RAM_en = 1'b0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'hA1 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        acc(1'b0, 16'd5, 16'h0);
        check("persist_addr5", dbus, 16'hBEEF);
        acc(1'b1, 16'd6, 16'h0606);
        acc(1'b0, 16'd0, 16'h0);
        check("reload_addr0", dbus, 16'h00A1);
        acc(1'b1, 16'd7, 16'h0707);
        acc(1'b0, 16'd6, 16'h0);
        check("readback_addr6", dbus, 16'h0606);
`ifdef RAM_ACCESS_STATS_EN
        check("stats_rd", rd_count, 32'd3);
        check("stats_wr", wr_count, 32'd2);
`else
        check("stats_rd_off", rd_count, 32'd0);
        check("stats_wr_off", wr_count, 32'd0);
`endif

        End_of_process = 1'b1;
        step();
        End_of_process = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && ndump < 1; i++) step();
        check("mid_dump_one_word", ndump, 1);
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 16'h0000);
        check("mid_rst_proc_run", proc_run, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_dbus", dbus, 16'h0000);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
